mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: load/store unit sitting between execute and writeback.
// Memory ops walk IDLE -> REQ -> WAIT -> DONE over a valid/ready request
// channel and a response channel; all other instructions pass straight
// through with no stall.
// Optional feature: define MEM_MISALIGN_CHECK_EN to trap misaligned H/W/D
// accesses (misalign_o / misalign_cause_o) instead of issuing them.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic [7:0]  inst_type_i,
  input  logic        rd_ena_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [63:0] rd_data_i,
  input  logic [2:0]  ls_sel_i,
  input  logic [63:0] ls_addr_i,
  output logic        rd_ena_o,
  output logic [4:0]  rd_addr_o,
  output logic [63:0] rd_data_o,
  output logic [63:0] mem_pc_o,
  output logic [31:0] mem_inst_o,
  output logic        mem_stall_req,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [63:0] dmem_addr,
  output logic        dmem_wen,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_rsp_valid,
  input  logic [63:0] dmem_rdata,
  output logic        misalign_o,
  output logic [63:0] misalign_cause_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state;
  state_t next_state;

  logic        is_mem;
  logic        is_store;
  logic        misaligned;
  logic        start;
  logic [2:0]  off;
  logic [7:0]  base_strb;
  logic [63:0] load_shifted;
  logic [63:0] load_ext;
  logic [5:0]  unused_type;

  // Access context captured when an op leaves IDLE
  logic [63:0] addr_q;
  logic [2:0]  off_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        store_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic        rd_ena_q;
  logic [4:0]  rd_addr_q;
  logic [63:0] pc_q;
  logic [31:0] inst_q;
  logic [63:0] load_q;

  assign is_store    = inst_type_i[0];
  assign is_mem      = inst_type_i[0] | inst_type_i[1];
  assign off         = ls_addr_i[2:0];
  assign unused_type = inst_type_i[7:2];

`ifdef MEM_MISALIGN_CHECK_EN
  // An access is misaligned when its byte offset is not a multiple of its size
  always_comb begin
    case (ls_sel_i[1:0])
      2'b01:   misaligned = is_mem & off[0];
      2'b10:   misaligned = is_mem & (off[1:0] != 2'b00);
      2'b11:   misaligned = is_mem & (off != 3'b000);
      default: misaligned = 1'b0;
    endcase
  end

  assign misalign_o       = ~rst & (state == IDLE) & misaligned;
  assign misalign_cause_o = misalign_o ? (is_store ? 64'd6 : 64'd4) : 64'd0;
`else
  assign misaligned       = 1'b0;
  assign misalign_o       = 1'b0;
  assign misalign_cause_o = 64'd0;
`endif

  assign start = (state == IDLE) & is_mem & ~misaligned;

  // Unshifted byte-enable pattern for the access size
  always_comb begin
    case (ls_sel_i[1:0])
      2'b00:   base_strb = 8'h01;
      2'b01:   base_strb = 8'h03;
      2'b10:   base_strb = 8'h0F;
      default: base_strb = 8'hFF;
    endcase
  end

  // Align the returned doubleword to the access and extend to 64 bits
  always_comb begin
    load_shifted = dmem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {56'd0, load_shifted[7:0]}
                                     : {{56{load_shifted[7]}}, load_shifted[7:0]};
      2'b01:   load_ext = unsigned_q ? {48'd0, load_shifted[15:0]}
                                     : {{48{load_shifted[15]}}, load_shifted[15:0]};
      2'b10:   load_ext = unsigned_q ? {32'd0, load_shifted[31:0]}
                                     : {{32{load_shifted[31]}}, load_shifted[31:0]};
      default: load_ext = load_shifted;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = REQ;
      REQ:     if (dmem_req_ready) next_state = WAIT;
      WAIT:    if (dmem_rsp_valid) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latch the access on entry to REQ and the load result on the response
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      off_q      <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      store_q    <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rd_ena_q   <= 1'b0;
      rd_addr_q  <= '0;
      pc_q       <= '0;
      inst_q     <= '0;
      load_q     <= '0;
    end else begin
      if (start) begin
        addr_q     <= {ls_addr_i[63:3], 3'b000};
        off_q      <= off;
        size_q     <= ls_sel_i[1:0];
        unsigned_q <= ls_sel_i[2];
        store_q    <= is_store;
        wdata_q    <= rd_data_i << {off, 3'b000};
        wstrb_q    <= base_strb << off;
        rd_ena_q   <= rd_ena_i;
        rd_addr_q  <= rd_addr_i;
        pc_q       <= pc_i;
        inst_q     <= inst_i;
      end
      if ((state == WAIT) && dmem_rsp_valid && !store_q) begin
        load_q <= load_ext;
      end
    end
  end

  // Drive pipeline and memory outputs from the current state; all quiet under reset
  always_comb begin
    rd_ena_o       = 1'b0;
    rd_addr_o      = '0;
    rd_data_o      = '0;
    mem_pc_o       = '0;
    mem_inst_o     = '0;
    mem_stall_req  = 1'b0;
    dmem_req_valid = 1'b0;
    dmem_addr      = '0;
    dmem_wen       = 1'b0;
    dmem_wdata     = '0;
    dmem_wstrb     = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          mem_pc_o      = pc_i;
          mem_inst_o    = inst_i;
          mem_stall_req = is_mem & ~misaligned;
          if (!is_mem) begin
            rd_ena_o  = rd_ena_i;
            rd_addr_o = rd_addr_i;
            rd_data_o = rd_data_i;
          end
        end
        REQ: begin
          mem_pc_o       = pc_q;
          mem_inst_o     = inst_q;
          mem_stall_req  = 1'b1;
          dmem_req_valid = 1'b1;
          dmem_addr      = addr_q;
          dmem_wen       = store_q;
          dmem_wdata     = wdata_q;
          dmem_wstrb     = wstrb_q;
        end
        WAIT: begin
          mem_pc_o      = pc_q;
          mem_inst_o    = inst_q;
          mem_stall_req = 1'b1;
        end
        DONE: begin
          mem_pc_o   = pc_q;
          mem_inst_o = inst_q;
          rd_ena_o   = rd_ena_q & ~store_q;
          rd_addr_o  = rd_addr_q;
          rd_data_o  = store_q ? 64'd0 : load_q;
        end
        default: begin
          mem_stall_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage.
// Expected values come from an arithmetic model of the access rules
// (aligned address, shifted data/strobes, extended load result) and a
// per-phase view of the handshake timing.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [63:0] pc_i;
  logic [31:0] inst_i;
  logic [7:0]  inst_type_i;
  logic        rd_ena_i;
  logic [4:0]  rd_addr_i;
  logic [63:0] rd_data_i;
  logic [2:0]  ls_sel_i;
  logic [63:0] ls_addr_i;
  logic        rd_ena_o;
  logic [4:0]  rd_addr_o;
  logic [63:0] rd_data_o;
  logic [63:0] mem_pc_o;
  logic [31:0] mem_inst_o;
  logic        mem_stall_req;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [63:0] dmem_addr;
  logic        dmem_wen;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rdata;
  logic        misalign_o;
  logic [63:0] misalign_cause_o;

  int errors;
  int checks;

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .pc_i             (pc_i),
    .inst_i           (inst_i),
    .inst_type_i      (inst_type_i),
    .rd_ena_i         (rd_ena_i),
    .rd_addr_i        (rd_addr_i),
    .rd_data_i        (rd_data_i),
    .ls_sel_i         (ls_sel_i),
    .ls_addr_i        (ls_addr_i),
    .rd_ena_o         (rd_ena_o),
    .rd_addr_o        (rd_addr_o),
    .rd_data_o        (rd_data_o),
    .mem_pc_o         (mem_pc_o),
    .mem_inst_o       (mem_inst_o),
    .mem_stall_req    (mem_stall_req),
    .dmem_req_valid   (dmem_req_valid),
    .dmem_req_ready   (dmem_req_ready),
    .dmem_addr        (dmem_addr),
    .dmem_wen         (dmem_wen),
    .dmem_wdata       (dmem_wdata),
    .dmem_wstrb       (dmem_wstrb),
    .dmem_rsp_valid   (dmem_rsp_valid),
    .dmem_rdata       (dmem_rdata),
    .misalign_o       (misalign_o),
    .misalign_cause_o (misalign_cause_o)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int accessBytes(input logic [2:0] sel);
    return 1 << sel[1:0];
  endfunction

  function automatic logic refMisaligned(input logic [2:0] sel, input logic [2:0] off);
    return (int'(off) % accessBytes(sel)) != 0;
  endfunction

  function automatic logic [63:0] refWdata(input logic [63:0] data, input logic [2:0] off);
    return data << (8 * off);
  endfunction

  function automatic logic [7:0] refWstrb(input logic [2:0] sel, input logic [2:0] off);
    logic [15:0] s;
    s = 16'((1 << accessBytes(sel)) - 1);
    s = s << off;
    return s[7:0];
  endfunction

  function automatic logic [63:0] refLoad(input logic [63:0] rdata, input logic [2:0] sel,
                                          input logic [2:0] off);
    int nbits;
    logic [63:0] v;
    logic [63:0] mask;
    nbits = 8 * accessBytes(sel);
    v = rdata >> (8 * off);
    if (nbits == 64) return v;
    mask = (64'd1 << nbits) - 64'd1;
    v = v & mask;
    if (!sel[2] && v[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic applyStimulus(input logic [7:0] itype, input logic [2:0] sel,
                               input logic [63:0] addr, input logic [63:0] data,
                               input logic en, input logic [4:0] rd,
                               input logic [63:0] pc, input logic [31:0] inst);
    inst_type_i = itype;
    ls_sel_i    = sel;
    ls_addr_i   = addr;
    rd_data_i   = data;
    rd_ena_i    = en;
    rd_addr_i   = rd;
    pc_i        = pc;
    inst_i      = inst;
  endtask

  // One non-memory instruction: everything passes through in the same cycle
  task automatic runAluOp(input logic [63:0] data, input logic en, input logic [4:0] rd);
    logic [63:0] pc;
    logic [31:0] inst;
    logic [7:0]  itype;
    pc    = {$urandom, $urandom};
    inst  = $urandom;
    itype = 8'($urandom) & 8'hFC;
    applyStimulus(itype, 3'($urandom), {$urandom, $urandom}, data, en, rd, pc, inst);
    dmem_req_ready = 1'($urandom);
    dmem_rsp_valid = 1'($urandom);
    dmem_rdata     = {$urandom, $urandom};
    #1;
    checkOutput("alu_rd_ena", rd_ena_o, en);
    checkOutput("alu_rd_addr", rd_addr_o, rd);
    checkOutput("alu_rd_data", rd_data_o, data);
    checkOutput("alu_pc", mem_pc_o, pc);
    checkOutput("alu_inst", mem_inst_o, inst);
    checkOutput("alu_stall", mem_stall_req, 0);
    checkOutput("alu_valid", dmem_req_valid, 0);
    @(negedge clk);
  endtask

  // One load or store with chosen ready/response delays, checked cycle by cycle
  task automatic runMemOp(input logic st, input logic [2:0] sel, input logic [63:0] addr,
                          input logic [63:0] sdata, input logic [63:0] rdata,
                          input int rdy_dly, input int rsp_dly,
                          output logic [63:0] seen_rd, output logic [63:0] seen_wdata,
                          output logic [7:0] seen_wstrb, output int valid_cycles,
                          output int latency);
    logic [2:0]  off;
    logic        mis;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    off  = addr[2:0];
    mis  = refMisaligned(sel, off);
    pc   = {$urandom, $urandom};
    inst = $urandom;
    rd   = 5'($urandom_range(1, 31));
    seen_rd      = '0;
    seen_wdata   = '0;
    seen_wstrb   = '0;
    valid_cycles = 0;
    latency      = 0;
    applyStimulus(st ? 8'h01 : 8'h02, sel, addr, sdata, 1'b1, rd, pc, inst);
    dmem_req_ready = 1'($urandom);
    dmem_rsp_valid = 1'($urandom);
    dmem_rdata     = {$urandom, $urandom};
    #1;
`ifdef MEM_MISALIGN_CHECK_EN
    if (mis) begin
      checkOutput("trap_flag", misalign_o, 1);
      checkOutput("trap_cause", misalign_cause_o, st ? 64'd6 : 64'd4);
      checkOutput("trap_stall", mem_stall_req, 0);
      checkOutput("trap_valid", dmem_req_valid, 0);
      checkOutput("trap_rd_ena", rd_ena_o, 0);
      @(negedge clk);
      applyStimulus(8'h00, 3'b000, 64'd0, 64'd0, 1'b0, 5'd0, 64'd0, 32'd0);
      #1;
      checkOutput("trap_after_valid", dmem_req_valid, 0);
      checkOutput("trap_after_flag", misalign_o, 0);
      @(negedge clk);
      return;
    end
`endif
    checkOutput("idle_stall", mem_stall_req, 1);
    checkOutput("idle_valid", dmem_req_valid, 0);
    checkOutput("idle_rd_ena", rd_ena_o, 0);
    checkOutput("idle_trap", misalign_o, 0);
    @(negedge clk);
    latency = 1;
    for (int k = 0; k <= rdy_dly; k++) begin
      dmem_req_ready = (k == rdy_dly);
      dmem_rsp_valid = 1'($urandom);
      dmem_rdata     = {$urandom, $urandom};
      #1;
      if (dmem_req_valid === 1'b1) valid_cycles++;
      if (k == 0) begin
        seen_wdata = dmem_wdata;
        seen_wstrb = dmem_wstrb;
      end
      checkOutput("req_valid", dmem_req_valid, 1);
      checkOutput("req_addr", dmem_addr, addr & ~64'h7);
      checkOutput("req_wen", dmem_wen, st);
      checkOutput("req_stall", mem_stall_req, 1);
      if (st) begin
        checkOutput("req_wdata", dmem_wdata, refWdata(sdata, off));
        checkOutput("req_wstrb", dmem_wstrb, refWstrb(sel, off));
      end
      @(negedge clk);
      latency++;
    end
    for (int k = 0; k <= rsp_dly; k++) begin
      dmem_req_ready = 1'($urandom);
      dmem_rsp_valid = (k == rsp_dly);
      dmem_rdata     = (k == rsp_dly) ? rdata : {$urandom, $urandom};
      #1;
      checkOutput("wait_valid", dmem_req_valid, 0);
      checkOutput("wait_stall", mem_stall_req, 1);
      checkOutput("wait_rd_ena", rd_ena_o, 0);
      @(negedge clk);
      latency++;
    end
    dmem_req_ready = 1'($urandom);
    dmem_rsp_valid = 1'($urandom);
    dmem_rdata     = {$urandom, $urandom};
    #1;
    seen_rd = rd_data_o;
    checkOutput("done_stall", mem_stall_req, 0);
    checkOutput("done_valid", dmem_req_valid, 0);
    checkOutput("done_rd_ena", rd_ena_o, !st);
    checkOutput("done_pc", mem_pc_o, pc);
    checkOutput("done_inst", mem_inst_o, inst);
    if (!st) begin
      checkOutput("done_rd_addr", rd_addr_o, rd);
      checkOutput("done_rd_data", rd_data_o, refLoad(rdata, sel, off));
    end
    @(negedge clk);
  endtask

  // Directed scenarios followed by a randomized mix of ALU, load and store ops
  initial begin
    logic [63:0] seen_rd;
    logic [63:0] seen_wdata;
    logic [7:0]  seen_wstrb;
    int          vc;
    int          lat;
    int          kind;
    logic        st;
    logic [2:0]  sel;

    errors = 0;
    checks = 0;
    rst = 1'b1;
    applyStimulus(8'h02, 3'b011, 64'h8000_0000, 64'h5, 1'b1, 5'd7, 64'h100, 32'h13);
    dmem_req_ready = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 64'h1;
    @(negedge clk);
    #1;
    checkOutput("rst_rd_ena", rd_ena_o, 0);
    checkOutput("rst_rd_data", rd_data_o, 0);
    checkOutput("rst_pc", mem_pc_o, 0);
    checkOutput("rst_inst", mem_inst_o, 0);
    checkOutput("rst_valid", dmem_req_valid, 0);
    checkOutput("rst_wen", dmem_wen, 0);
    checkOutput("rst_wstrb", dmem_wstrb, 0);
    checkOutput("rst_stall", mem_stall_req, 0);
    checkOutput("rst_trap", misalign_o, 0);
    applyStimulus(8'h00, 3'b000, 64'd0, 64'd0, 1'b0, 5'd0, 64'd0, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Sign-extended byte load at minimum latency
    runMemOp(1'b0, 3'b000, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0,
             seen_rd, seen_wdata, seen_wstrb, vc, lat);
    checkOutput("lb_result", seen_rd, 64'hFFFF_FFFF_FFFF_FF80);
    checkOutput("lb_latency", lat, 3);
    checkOutput("lb_valid_cycles", vc, 1);

    // Halfword store into the top of the doubleword
    runMemOp(1'b1, 3'b001, 64'h8000_0006, 64'h1234, {$urandom, $urandom}, 0, 0,
             seen_rd, seen_wdata, seen_wstrb, vc, lat);
    checkOutput("sh_wdata", seen_wdata, 64'h1234_0000_0000_0000);
    checkOutput("sh_wstrb", seen_wstrb, 8'hC0);

    // Unsigned word load with ready held low for five cycles
    runMemOp(1'b0, 3'b110, 64'h8000_0004, 64'd0, 64'hDEAD_BEEF_1234_5678, 5, 1,
             seen_rd, seen_wdata, seen_wstrb, vc, lat);
    checkOutput("lwu_result", seen_rd, 64'h0000_0000_DEAD_BEEF);
    checkOutput("lwu_valid_cycles", vc, 6);

    // Reset during WAIT, then a stray response
    applyStimulus(8'h02, 3'b011, 64'h8000_0010, 64'd0, 1'b1, 5'd9, 64'h1000, 32'h3);
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    #1;
    checkOutput("abort_idle_stall", mem_stall_req, 1);
    @(negedge clk);
    dmem_req_ready = 1'b1;
    #1;
    checkOutput("abort_req_valid", dmem_req_valid, 1);
    @(negedge clk);
    dmem_req_ready = 1'b0;
    #1;
    checkOutput("abort_wait_stall", mem_stall_req, 1);
    rst = 1'b1;
    #1;
    checkOutput("abort_rst_valid", dmem_req_valid, 0);
    checkOutput("abort_rst_stall", mem_stall_req, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h00, 3'b000, 64'd0, 64'd0, 1'b0, 5'd0, 64'd0, 32'd0);
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    checkOutput("abort_after_stall", mem_stall_req, 0);
    checkOutput("abort_after_valid", dmem_req_valid, 0);
    checkOutput("abort_after_rd_ena", rd_ena_o, 0);
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    #1;
    checkOutput("abort_late_rd_ena", rd_ena_o, 0);
    checkOutput("abort_late_valid", dmem_req_valid, 0);
    checkOutput("abort_late_stall", mem_stall_req, 0);
    @(negedge clk);

    // Misaligned word load
    runMemOp(1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 0,
             seen_rd, seen_wdata, seen_wstrb, vc, lat);
`ifdef MEM_MISALIGN_CHECK_EN
    checkOutput("lw_mis_valid_cycles", vc, 0);
`else
    checkOutput("lw_mis_latency", lat, 3);
    checkOutput("lw_mis_result", seen_rd, 64'h0000_0000_4567_89AB);
`endif

    // Plain ALU passthrough
    runAluOp(64'h5, 1'b1, 5'd3);

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        runAluOp({$urandom, $urandom}, 1'($urandom), 5'($urandom));
      end else begin
        st  = (kind == 2);
        sel = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
        runMemOp(st, sel, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 seen_rd, seen_wdata, seen_wstrb, vc, lat);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
